cpu_id_stage: RTL and testbench
===============================

# cpu_id_stage

Parametrised decode stage for the pipelined CPU, sitting between the IF/ID and ID/EX boundaries. It decodes the 16-bit instruction, reads an internal register file with write-back bypass, and resolves B/BR branches against the flag register. It detects load-use, flag and branch-register hazards and generates stalls. It also owns the ID/EX pipeline register, inserts bubbles, and latches a halt state after HLT.

## Interface
Parameters:
- DATA_W, 16: datapath and register width (≥16).
- NREG, 16: register count, power of two ≤16; address width AW = log2(NREG), taken from the low bits of each 4-bit register field.
- BYPASS, 1: 1 = WB write visible to same-cycle ID read; 0 = no bypass.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  IF/ID holds a real instruction.
- instr  in  16  instruction.
- pc_plus2  in  DATA_W  address of instruction + 2.
- flags  in  3  committed {Z,V,N}.
- exmem_rd  in  AW  destination of the instruction in MEM.
- exmem_reg_write  in  1  MEM instruction writes exmem_rd.
- wb_we  in  1  write-back enable.
- wb_addr  in  AW  write-back address.
- wb_data  in  DATA_W  write-back data.
- stall  out  1  hold PC and IF/ID (combinational).
- branch_taken  out  1  redirect fetch, kill fetched instruction (combinational).
- branch_target  out  DATA_W  redirect address.
- idex_valid  out  1  ID/EX holds a real instruction.
- idex_opcode  out  4  opcode.
- idex_rs1, idex_rs2, idex_rd  out  AW each  register indices.
- idex_rs1_data, idex_rs2_data  out  DATA_W each  operand values.
- idex_imm  out  DATA_W  extended immediate.
- idex_alu_src, idex_mem_read, idex_mem_write, idex_mem_to_reg, idex_reg_write, idex_pcs, idex_halt  out  1 each  controls.

## Operation
- Opcodes: 0000 ADD, 0001 SUB, 0010 XOR, 0011 RED, 0100 SLL, 0101 SRA, 0110 ROR, 0111 PADDSB, 1000 LW, 1001 SW, 1010 LLB, 1011 LHB, 1100 B, 1101 BR, 1110 PCS, 1111 HLT.
- Fields:
  - rd = instr[11:8].
  - rs1 = instr[7:4]; LLB/LHB use instr[11:8].
  - rs2 = instr[3:0]; SW uses instr[11:8].
- Immediates:
  - LW/SW: sign-extended instr[3:0] shifted left 1.
  - LLB/LHB: zero-extended instr[7:0].
  - Shifts/rotates: zero-extended instr[3:0].
  - All others: 0.
- Register file: NREG×DATA_W, register 0 reads 0 and ignores writes.
  - Write on clk when wb_we.
  - BYPASS=1: a read of wb_addr≠0 while wb_we returns wb_data.
- rs1/rs2 usage:
  - ADD–PADDSB use both, except shifts/ROR, which use rs1 only.
  - LW uses rs1; SW uses both; LLB/LHB use rs1; BR uses rs1.
- Branch conditions (instr[11:9]):
  - 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1.
  - 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
- Branch targets:
  - B: pc_plus2 + (sext(instr[8:0])<<1), modulo 2^DATA_W.
  - BR: rs1 data.
- Flag setters: ADD, SUB, XOR, SLL, SRA, ROR.
- Hazards; stall=1 if id_valid & !halted and any of:
  - Load-use: idex_valid & idex_mem_read & idex_rd≠0 & idex_rd matches a used source.
  - Flag: conditional B/BR (cond≠111) & idex_valid & idex opcode is a flag setter.
  - BR register: rs1≠0 and equals idex_rd (idex_valid & idex_reg_write) or exmem_rd (exmem_reg_write).
- branch_taken = id_valid & !stall & !halted & (B|BR) & condition true.
- ID/EX update on each clk:
  - Bubble when stall, !id_valid or halted: idex_valid and all controls ← 0.
  - Otherwise all fields ← decoded values.
  - B/BR load with idex_reg_write=0.
- Halt state: HLT loaded into ID/EX sets halted.
  - While halted: stall=1, branch_taken=0, only bubbles issue.
  - Cleared only by reset.

## Timing
- Reset (async assert, sync to clk on release): every idex_* output 0, halted 0, register file all 0.
  - Combinational outputs then follow inputs (branch_target still computed; branch_taken gated).
- Latency: decoded instruction appears on idex_* 1 cycle after acceptance.
  - Branch decision is same-cycle.
- Stall: the instruction stays in IF/ID, and the cycle retries; one bubble is inserted per stalled cycle.
  - Load-use: 1 bubble.
  - Flag: 1 bubble.
  - BR register: up to 2 bubbles.
- Simultaneous events:
  - WB write and read of the same register resolve by BYPASS.
  - A stall suppresses branch_taken.
  - Reset asserted mid-stall clears immediately.

## Test plan
- ADD R3,R1,R2 with R1=5, R2=7 preloaded via WB -> next cycle idex_valid=1, rs1_data=5, rs2_data=7, idex_rd=3, idex_reg_write=1.
- LW R4,[R1+2] then ADD R5,R4,R2 -> stall=1 for exactly 1 cycle, one bubble (idex_valid=0), ADD then issues.
- SUB in ID/EX followed by conditional B (cond 001) with Z=1 -> stall 1 cycle, then branch_taken=1, target = pc_plus2 + 2*imm (imm=-3, pc_plus2=0x0010 gives 0x000A).
- WB writes R6=0xBEEF while ID reads R6: BYPASS=1 -> rs1_data 0xBEEF; BYPASS=0 -> old value. Writes to R0 read back 0.
- BR R7 with exmem_rd=7 and exmem_reg_write=1 -> stall held, then branch_target = R7 value once cleared.
- HLT issued -> idex_halt=1 next cycle, then stall=1 and idex_valid=0 permanently; async rst_n low clears all outputs to 0.

Source files
------------

// File: rtl/cpu_id_stage.sv
// Decode stage: instruction decode, register file with write-back bypass,
// B/BR resolution, hazard/stall generation, ID/EX register and halt latch.
module cpu_id_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 16,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [15:0]       instr,
  input  logic [DATA_W-1:0] pc_plus2,
  input  logic [2:0]        flags,
  input  logic [AW-1:0]     exmem_rd,
  input  logic              exmem_reg_write,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic              idex_valid,
  output logic [3:0]        idex_opcode,
  output logic [AW-1:0]     idex_rs1,
  output logic [AW-1:0]     idex_rs2,
  output logic [AW-1:0]     idex_rd,
  output logic [DATA_W-1:0] idex_rs1_data,
  output logic [DATA_W-1:0] idex_rs2_data,
  output logic [DATA_W-1:0] idex_imm,
  output logic              idex_alu_src,
  output logic              idex_mem_read,
  output logic              idex_mem_write,
  output logic              idex_mem_to_reg,
  output logic              idex_reg_write,
  output logic              idex_pcs,
  output logic              idex_halt
);

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3,
    OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PADDSB = 4'h7,
    OP_LW  = 4'h8, OP_SW  = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB,
    OP_B   = 4'hC, OP_BR  = 4'hD, OP_PCS = 4'hE, OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  typedef struct packed {
    logic              valid;
    logic [3:0]        opcode;
    logic [AW-1:0]     rs1;
    logic [AW-1:0]     rs2;
    logic [AW-1:0]     rd;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic              alu_src;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic              pcs;
    logic              halt;
  } idex_t;

  state_e            state_q, state_d;
  idex_t             idex_q, idex_d;
  logic [DATA_W-1:0] rf_q [NREG];

  opcode_e           op;
  logic [AW-1:0]     rs1_a, rs2_a, rd_a;
  logic              use_rs1, use_rs2, is_b, is_br, cond_true;
  logic              alu_src, reg_write;
  logic [DATA_W-1:0] imm, rs1_val, rs2_val;
  logic              load_use, flag_hz, br_hz, halted, issue;

  assign op     = opcode_e'(instr[15:12]);
  assign halted = (state_q == ST_HALT);

  // Field selection, immediate formation and per-opcode control decode
  always_comb begin
    rd_a      = instr[8 +: AW];
    rs1_a     = (op == OP_LLB || op == OP_LHB) ? instr[8 +: AW] : instr[4 +: AW];
    rs2_a     = (op == OP_SW) ? instr[8 +: AW] : instr[0 +: AW];
    is_b      = (op == OP_B);
    is_br     = (op == OP_BR);
    use_rs1   = !(op inside {OP_B, OP_PCS, OP_HLT});
    use_rs2   = op inside {OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB, OP_SW};
    alu_src   = op inside {OP_SLL, OP_SRA, OP_ROR, OP_LW, OP_SW, OP_LLB, OP_LHB};
    reg_write = !(op inside {OP_SW, OP_B, OP_BR, OP_HLT});
    imm       = '0;
    case (op)
      OP_LW, OP_SW:           imm = {{(DATA_W-5){instr[3]}}, instr[3:0], 1'b0};
      OP_LLB, OP_LHB:         imm = {{(DATA_W-8){1'b0}}, instr[7:0]};
      OP_SLL, OP_SRA, OP_ROR: imm = {{(DATA_W-4){1'b0}}, instr[3:0]};
      default:                imm = '0;
    endcase
  end

  // Register file reads; register 0 is hard zero, WB optionally bypassed
  always_comb begin
    rs1_val = rf_q[rs1_a];
    rs2_val = rf_q[rs2_a];
    if (BYPASS != 0 && wb_we && wb_addr == rs1_a) rs1_val = wb_data;
    if (BYPASS != 0 && wb_we && wb_addr == rs2_a) rs2_val = wb_data;
    if (rs1_a == '0) rs1_val = '0;
    if (rs2_a == '0) rs2_val = '0;
  end

  // Branch condition on committed {Z,V,N}
  always_comb begin
    cond_true = 1'b0;
    case (instr[11:9])
      3'b000: cond_true = !flags[2];
      3'b001: cond_true = flags[2];
      3'b010: cond_true = !flags[2] && !flags[0];
      3'b011: cond_true = flags[0];
      3'b100: cond_true = flags[2] || (!flags[2] && !flags[0]);
      3'b101: cond_true = flags[0] || flags[2];
      3'b110: cond_true = flags[1];
      default: cond_true = 1'b1;
    endcase
  end

  // Hazard detection, stall and branch redirect
  always_comb begin
    load_use = idex_q.valid && idex_q.mem_read && (idex_q.rd != '0) &&
               ((use_rs1 && rs1_a == idex_q.rd) || (use_rs2 && rs2_a == idex_q.rd));
    flag_hz  = (is_b || is_br) && (instr[11:9] != 3'b111) && idex_q.valid &&
               (idex_q.opcode inside {OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRA, OP_ROR});
    br_hz    = is_br && (rs1_a != '0) &&
               ((idex_q.valid && idex_q.reg_write && rs1_a == idex_q.rd) ||
                (exmem_reg_write && rs1_a == exmem_rd));
    stall         = halted || (id_valid && (load_use || flag_hz || br_hz));
    issue         = id_valid && !stall;
    branch_taken  = issue && (is_b || is_br) && cond_true;
    branch_target = is_br ? rs1_val
                          : pc_plus2 + {{(DATA_W-10){instr[8]}}, instr[8:0], 1'b0};
  end

  // Next ID/EX contents: decoded instruction on issue, otherwise a bubble
  always_comb begin
    idex_d = '0;
    if (issue) begin
      idex_d.valid      = 1'b1;
      idex_d.opcode     = instr[15:12];
      idex_d.rs1        = rs1_a;
      idex_d.rs2        = rs2_a;
      idex_d.rd         = rd_a;
      idex_d.rs1_data   = rs1_val;
      idex_d.rs2_data   = rs2_val;
      idex_d.imm        = imm;
      idex_d.alu_src    = alu_src;
      idex_d.mem_read   = (op == OP_LW);
      idex_d.mem_write  = (op == OP_SW);
      idex_d.mem_to_reg = (op == OP_LW);
      idex_d.reg_write  = reg_write;
      idex_d.pcs        = (op == OP_PCS);
      idex_d.halt       = (op == OP_HLT);
    end
  end

  // Halt latch: entered when HLT is loaded into ID/EX, left only via reset
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && issue && op == OP_HLT) state_d = ST_HALT;
  end

  // State, ID/EX register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      idex_q  <= '0;
    end else begin
      state_q <= state_d;
      idex_q  <= idex_d;
    end
  end

  // Register file write port; writes to register 0 are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_we && wb_addr != '0) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  assign idex_valid      = idex_q.valid;
  assign idex_opcode     = idex_q.opcode;
  assign idex_rs1        = idex_q.rs1;
  assign idex_rs2        = idex_q.rs2;
  assign idex_rd         = idex_q.rd;
  assign idex_rs1_data   = idex_q.rs1_data;
  assign idex_rs2_data   = idex_q.rs2_data;
  assign idex_imm        = idex_q.imm;
  assign idex_alu_src    = idex_q.alu_src;
  assign idex_mem_read   = idex_q.mem_read;
  assign idex_mem_write  = idex_q.mem_write;
  assign idex_mem_to_reg = idex_q.mem_to_reg;
  assign idex_reg_write  = idex_q.reg_write;
  assign idex_pcs        = idex_q.pcs;
  assign idex_halt       = idex_q.halt;

endmodule

// File: tb/tb_cpu_id_stage.sv
// Bench for cpu_id_stage: directed scenarios then random instructions,
// checked against a table-driven decode model. A second instance without
// bypass shares all inputs.
module tb_cpu_id_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic id_valid = 1'b0;
  logic [15:0] instr = '0, pc_plus2 = '0, wb_data = '0;
  logic [2:0] flags = '0;
  logic [3:0] exmem_rd = '0, wb_addr = '0;
  logic exmem_reg_write = 1'b0, wb_we = 1'b0;

  logic stall, branch_taken, idex_valid;
  logic [15:0] branch_target, idex_rs1_data, idex_rs2_data, idex_imm;
  logic [3:0] idex_opcode, idex_rs1, idex_rs2, idex_rd;
  logic idex_alu_src, idex_mem_read, idex_mem_write, idex_mem_to_reg;
  logic idex_reg_write, idex_pcs, idex_halt;

  logic z_stall, z_branch_taken, z_idex_valid;
  logic [15:0] z_branch_target, z_idex_rs1_data, z_idex_rs2_data, z_idex_imm;
  logic [3:0] z_idex_opcode, z_idex_rs1, z_idex_rs2, z_idex_rd;
  logic z_idex_alu_src, z_idex_mem_read, z_idex_mem_write, z_idex_mem_to_reg;
  logic z_idex_reg_write, z_idex_pcs, z_idex_halt;

  cpu_id_stage #(.DATA_W(16), .NREG(16), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .instr(instr), .pc_plus2(pc_plus2),
    .flags(flags), .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .idex_valid(idex_valid), .idex_opcode(idex_opcode), .idex_rs1(idex_rs1),
    .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_rs1_data(idex_rs1_data),
    .idex_rs2_data(idex_rs2_data), .idex_imm(idex_imm), .idex_alu_src(idex_alu_src),
    .idex_mem_read(idex_mem_read), .idex_mem_write(idex_mem_write),
    .idex_mem_to_reg(idex_mem_to_reg), .idex_reg_write(idex_reg_write),
    .idex_pcs(idex_pcs), .idex_halt(idex_halt));

  cpu_id_stage #(.DATA_W(16), .NREG(16), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .instr(instr), .pc_plus2(pc_plus2),
    .flags(flags), .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(z_stall), .branch_taken(z_branch_taken), .branch_target(z_branch_target),
    .idex_valid(z_idex_valid), .idex_opcode(z_idex_opcode), .idex_rs1(z_idex_rs1),
    .idex_rs2(z_idex_rs2), .idex_rd(z_idex_rd), .idex_rs1_data(z_idex_rs1_data),
    .idex_rs2_data(z_idex_rs2_data), .idex_imm(z_idex_imm), .idex_alu_src(z_idex_alu_src),
    .idex_mem_read(z_idex_mem_read), .idex_mem_write(z_idex_mem_write),
    .idex_mem_to_reg(z_idex_mem_to_reg), .idex_reg_write(z_idex_reg_write),
    .idex_pcs(z_idex_pcs), .idex_halt(z_idex_halt));

  always #5 clk = ~clk;

  // Model state: expected ID/EX contents, register file, halt flag
  typedef struct packed {
    bit v; bit [3:0] op, rs1, rs2, rd;
    bit [15:0] d1, d2, d1n, d2n, imm;
    bit alu, mr, mw, m2r, rw, pcs, hlt;
  } ex_t;

  ex_t mx;
  bit [15:0] mrf [16];
  bit mh;
  int total = 0, bad = 0;
  logic obs_stall, obs_bt;
  logic [15:0] obs_tgt;

  // Opcode property tables, bit n = opcode n
  bit [15:0] USE1 = 16'h2FFF;
  bit [15:0] USE2 = 16'h028F;
  bit [15:0] RW   = 16'h4DFF;
  bit [15:0] FLG  = 16'h0077;
  bit [15:0] ALU  = 16'h0F70;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_ok(input bit [2:0] c, input bit [2:0] f);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit [15:0] rdreg(input bit [3:0] a, input bit byp);
    if (a == 0) return 16'h0;
    if (byp && wb_we && wb_addr == a) return wb_data;
    return mrf[a];
  endfunction

  task automatic check_idex();
    chk("valid", idex_valid, mx.v);       chk("opcode", idex_opcode, mx.op);
    chk("rs1", idex_rs1, mx.rs1);         chk("rs2", idex_rs2, mx.rs2);
    chk("rd", idex_rd, mx.rd);            chk("rs1_data", idex_rs1_data, mx.d1);
    chk("rs2_data", idex_rs2_data, mx.d2); chk("imm", idex_imm, mx.imm);
    chk("alu_src", idex_alu_src, mx.alu); chk("mem_read", idex_mem_read, mx.mr);
    chk("mem_write", idex_mem_write, mx.mw); chk("mem_to_reg", idex_mem_to_reg, mx.m2r);
    chk("reg_write", idex_reg_write, mx.rw); chk("pcs", idex_pcs, mx.pcs);
    chk("halt", idex_halt, mx.hlt);
    chk("nb_valid", z_idex_valid, mx.v);  chk("nb_opcode", z_idex_opcode, mx.op);
    chk("nb_rs1", z_idex_rs1, mx.rs1);    chk("nb_rs2", z_idex_rs2, mx.rs2);
    chk("nb_rd", z_idex_rd, mx.rd);       chk("nb_rs1_data", z_idex_rs1_data, mx.d1n);
    chk("nb_rs2_data", z_idex_rs2_data, mx.d2n); chk("nb_imm", z_idex_imm, mx.imm);
    chk("nb_ctl", {z_idex_alu_src, z_idex_mem_read, z_idex_mem_write, z_idex_mem_to_reg,
                   z_idex_reg_write, z_idex_pcs, z_idex_halt},
        {mx.alu, mx.mr, mx.mw, mx.m2r, mx.rw, mx.pcs, mx.hlt});
  endtask

  // One clock: check combinational outputs mid-cycle, then the registered result
  task automatic cycle();
    bit [3:0] op;
    ex_t nx;
    bit lu, fh, bh, st, bt, isbr;
    bit signed [15:0] s4, s9;
    bit [15:0] tgt, tgtn;
    @(negedge clk);
    op = instr[15:12];
    nx = '0;
    nx.v = 1'b1; nx.op = op; nx.rd = instr[11:8];
    nx.rs1 = (op == 10 || op == 11) ? instr[11:8] : instr[7:4];
    nx.rs2 = (op == 9) ? instr[11:8] : instr[3:0];
    nx.d1 = rdreg(nx.rs1, 1'b1);  nx.d2 = rdreg(nx.rs2, 1'b1);
    nx.d1n = rdreg(nx.rs1, 1'b0); nx.d2n = rdreg(nx.rs2, 1'b0);
    s4 = $signed(instr[3:0]);
    case (op)
      8, 9:    nx.imm = s4 * 2;
      10, 11:  nx.imm = {8'h00, instr[7:0]};
      4, 5, 6: nx.imm = {12'h000, instr[3:0]};
      default: nx.imm = 16'h0;
    endcase
    nx.alu = ALU[op]; nx.mr = (op == 8); nx.mw = (op == 9); nx.m2r = (op == 8);
    nx.rw = RW[op]; nx.pcs = (op == 14); nx.hlt = (op == 15);
    isbr = (op == 12 || op == 13);
    lu = mx.v && mx.mr && mx.rd != 0 &&
         ((USE1[op] && nx.rs1 == mx.rd) || (USE2[op] && nx.rs2 == mx.rd));
    fh = isbr && instr[11:9] != 3'd7 && mx.v && FLG[mx.op];
    bh = op == 13 && nx.rs1 != 0 &&
         ((mx.v && mx.rw && nx.rs1 == mx.rd) || (exmem_reg_write && nx.rs1 == exmem_rd));
    st = mh || (id_valid && (lu || fh || bh));
    bt = id_valid && !st && isbr && cond_ok(instr[11:9], flags);
    obs_stall = stall; obs_bt = branch_taken; obs_tgt = branch_target;
    chk("stall", stall, st);              chk("branch_taken", branch_taken, bt);
    chk("nb_stall", z_stall, st);         chk("nb_branch_taken", z_branch_taken, bt);
    if (isbr) begin
      s9 = $signed(instr[8:0]);
      tgt = (op == 13) ? nx.d1 : pc_plus2 + s9 * 2;
      tgtn = (op == 13) ? nx.d1n : tgt;
      chk("branch_target", branch_target, tgt);
      chk("nb_branch_target", z_branch_target, tgtn);
    end
    if (st || !id_valid) nx = '0;
    @(posedge clk);
    #1;
    if (wb_we && wb_addr != 0) mrf[wb_addr] = wb_data;
    mx = nx;
    if (nx.hlt) mh = 1'b1;
    check_idex();
  endtask

  task automatic model_reset();
    mx = '0; mh = 1'b0;
    for (int i = 0; i < 16; i++) mrf[i] = 16'h0;
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #11;
    check_idex();
    chk("reset_stall", stall, 1'b0);
    chk("reset_bt", branch_taken, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Preload R1=5, R2=7, then ADD R3,R1,R2
    wb_we = 1; wb_addr = 1; wb_data = 16'd5; cycle();
    wb_addr = 2; wb_data = 16'd7; cycle();
    wb_we = 0;
    id_valid = 1; instr = 16'h0312; cycle();
    chk("add_valid", idex_valid, 1'b1);   chk("add_rs1_data", idex_rs1_data, 16'd5);
    chk("add_rs2_data", idex_rs2_data, 16'd7); chk("add_rd", idex_rd, 4'd3);
    chk("add_reg_write", idex_reg_write, 1'b1);

    // Load-use: LW R4,[R1+2] then ADD R5,R4,R2
    instr = 16'h8411; cycle();
    chk("lw_imm", idex_imm, 16'd2);
    instr = 16'h0542; cycle();
    chk("lu_stall1", obs_stall, 1'b1);    chk("lu_bubble", idex_valid, 1'b0);
    cycle();
    chk("lu_stall2", obs_stall, 1'b0);    chk("lu_issue", idex_rd, 4'd5);

    // Flag hazard: SUB then B cond=001 offset -3 with Z=1
    instr = 16'h1112; cycle();
    instr = 16'hC3FD; pc_plus2 = 16'h0010; flags = 3'b100; cycle();
    chk("flag_stall", obs_stall, 1'b1);   chk("flag_bt_held", obs_bt, 1'b0);
    cycle();
    chk("flag_stall_clear", obs_stall, 1'b0); chk("b_taken", obs_bt, 1'b1);
    chk("b_target", obs_tgt, 16'h000A);   chk("b_no_reg_write", idex_reg_write, 1'b0);

    // Same-cycle WB/read of R6, then R0 write attempt
    instr = 16'h0760; wb_we = 1; wb_addr = 6; wb_data = 16'hBEEF; cycle();
    chk("bypass_on", idex_rs1_data, 16'hBEEF); chk("bypass_off", z_idex_rs1_data, 16'h0);
    instr = 16'h0800; wb_addr = 0; wb_data = 16'h1234; cycle();
    chk("r0_read", idex_rs1_data, 16'h0);
    instr = 16'h0960; wb_we = 0; cycle();
    chk("r6_committed", z_idex_rs1_data, 16'hBEEF);

    // BR R7 blocked by MEM writer of R7
    id_valid = 0; wb_we = 1; wb_addr = 7; wb_data = 16'h0040; cycle();
    wb_we = 0; id_valid = 1; instr = 16'hDE70; exmem_rd = 7; exmem_reg_write = 1;
    cycle(); chk("br_stall1", obs_stall, 1'b1);
    cycle(); chk("br_stall2", obs_stall, 1'b1);
    exmem_reg_write = 0; cycle();
    chk("br_taken", obs_bt, 1'b1);        chk("br_target", obs_tgt, 16'h0040);

    // Random traffic, HLT excluded
    for (int n = 0; n < 400; n++) begin
      id_valid = ($urandom_range(0, 7) != 0);
      instr = {4'($urandom_range(0, 14)), 12'($urandom)};
      pc_plus2 = 16'($urandom);   flags = 3'($urandom);
      exmem_rd = 4'($urandom);    exmem_reg_write = 1'($urandom);
      wb_we = 1'($urandom);       wb_addr = 4'($urandom); wb_data = 16'($urandom);
      cycle();
    end

    // HLT then permanent bubbles
    id_valid = 1; instr = 16'hF000; wb_we = 0; exmem_reg_write = 0; cycle();
    chk("hlt_issue", idex_halt, 1'b1);
    instr = 16'h0312; cycle();
    chk("halted_stall", obs_stall, 1'b1); chk("halted_bubble", idex_valid, 1'b0);
    instr = 16'hCE00; cycle();
    chk("halted_no_branch", obs_bt, 1'b0);
    instr = 16'h0312; cycle(); cycle();
    chk("halted_persist", obs_stall, 1'b1);

    // Asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_idex();
    chk("async_stall", stall, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    instr = 16'h0312; cycle();
    chk("rf_cleared", idex_rs1_data, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
